// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl
// Purpose  : Sequences HI/LO register updates for MULT/MULTU/DIV/DIVU and
//            MTHI/MTLO. Launches the multiplier/divider, waits for its done
//            pulse (with a timeout abort), then writes HI and LO.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic       div_zero,
  input  logic       unit_done,
  output logic       unit_start,
  output logic       unit_sel,
  output logic       unit_signed,
  output logic       hi_ena,
  output logic       lo_ena,
  output logic       hi_src,
  output logic       stall,
  output logic       op_ack,
  output logic       err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unit_start_q, unit_start_d;
  logic             unit_sel_q, unit_sel_d;
  logic             unit_signed_q, unit_signed_d;
  logic             hi_ena_q, hi_ena_d;
  logic             lo_ena_q, lo_ena_d;
  logic             hi_src_q, hi_src_d;
  logic             op_ack_q, op_ack_d;
  logic             err_q, err_d;

  logic             is_unit_op;
  logic             is_div_op;
  logic             accept;
  logic             stall_raw;
  logic [CNT_W-1:0] cnt_inc;

  // Instruction decode: which ops launch the arithmetic unit.
  always_comb begin
    is_div_op  = (op_code == OP_DIV) || (op_code == OP_DIVU);
    is_unit_op = (op_code == OP_MULT) || (op_code == OP_MULTU) || is_div_op;
    accept     = op_valid && is_unit_op && !(is_div_op && div_zero);
    cnt_inc    = cnt_q + 1'b1;
  end

  // Next-state and registered-output logic; every pulse output defaults low.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    unit_start_d  = 1'b0;
    unit_sel_d    = unit_sel_q;
    unit_signed_d = unit_signed_q;
    hi_ena_d      = 1'b0;
    lo_ena_d      = 1'b0;
    hi_src_d      = 1'b0;
    op_ack_d      = 1'b0;
    err_d         = err_q;
    stall_raw     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d       = S_START;
          unit_start_d  = 1'b1;
          unit_sel_d    = is_div_op;
          unit_signed_d = (op_code == OP_MULT) || (op_code == OP_DIV);
          stall_raw     = 1'b1;
        end else if (op_valid) begin
          // Non-launching ops retire in a single cycle without stalling.
          if (op_code == OP_MTHI) begin
            hi_ena_d = 1'b1;
            hi_src_d = 1'b1;
            op_ack_d = 1'b1;
          end else if (op_code == OP_MTLO) begin
            lo_ena_d = 1'b1;
            hi_src_d = 1'b1;
            op_ack_d = 1'b1;
          end else if (is_div_op) begin
            // Divide by zero: retire with HI/LO untouched.
            op_ack_d = 1'b1;
          end
        end
      end

      S_START: begin
        stall_raw = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_inc;
        // Done takes priority over a timeout landing in the same cycle.
        if (unit_done) begin
          state_d  = S_WRITE;
          hi_ena_d = 1'b1;
          lo_ena_d = 1'b1;
          op_ack_d = 1'b1;
        end else if (cnt_inc == TMO_CNT) begin
          state_d  = S_IDLE;
          err_d    = 1'b1;
          op_ack_d = 1'b1;
          cnt_d    = '0;
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      unit_start_q  <= 1'b0;
      unit_sel_q    <= 1'b0;
      unit_signed_q <= 1'b0;
      hi_ena_q      <= 1'b0;
      lo_ena_q      <= 1'b0;
      hi_src_q      <= 1'b0;
      op_ack_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      unit_start_q  <= unit_start_d;
      unit_sel_q    <= unit_sel_d;
      unit_signed_q <= unit_signed_d;
      hi_ena_q      <= hi_ena_d;
      lo_ena_q      <= lo_ena_d;
      hi_src_q      <= hi_src_d;
      op_ack_q      <= op_ack_d;
      err_q         <= err_d;
    end
  end

  // Stall is combinational so the accept cycle itself freezes the PC;
  // it is forced low while reset is held.
  always_comb begin
    stall = rst && stall_raw;
  end

  assign unit_start  = unit_start_q;
  assign unit_sel    = unit_sel_q;
  assign unit_signed = unit_signed_q;
  assign hi_ena      = hi_ena_q;
  assign lo_ena      = lo_ena_q;
  assign hi_src      = hi_src_q;
  assign op_ack      = op_ack_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_ctrl
// Purpose  : Self-checking bench for hilo_ctrl: table-driven per-cycle
//            vectors plus directed sequences for timeout, the done/timeout
//            boundary and reset during an operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [2:0] op_code;
  logic       div_zero;
  logic       unit_done;
  logic       unit_start, unit_sel, unit_signed;
  logic       hi_ena, lo_ena, hi_src, stall, op_ack, err;

  int total = 0;
  int bad   = 0;

  // Per-cycle record: inputs for the cycle and outputs expected during it.
  // exp = {stall, unit_start, unit_sel, unit_signed, hi_ena, lo_ena,
  //        hi_src, op_ack, err}
  typedef struct {
    logic       opv;
    logic [2:0] code;
    logic       dz;
    logic       done;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[25];

  hilo_ctrl #(.TIMEOUT(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .div_zero   (div_zero),
    .unit_done  (unit_done),
    .unit_start (unit_start),
    .unit_sel   (unit_sel),
    .unit_signed(unit_signed),
    .hi_ena     (hi_ena),
    .lo_ena     (lo_ena),
    .hi_src     (hi_src),
    .stall      (stall),
    .op_ack     (op_ack),
    .err        (err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] outs();
    return {stall, unit_start, unit_sel, unit_signed, hi_ena, lo_ena,
            hi_src, op_ack, err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b required %0b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] c,
                       input logic z, input logic d);
    op_valid  = v;
    op_code   = c;
    div_zero  = z;
    unit_done = d;
  endtask

  initial begin
    int  waits;
    logic ack_seen;
    logic stall_ok;

    // MULT, done 3 cycles after start
    vecs[0]  = '{1'b1, 3'b001, 1'b0, 1'b0, 9'b100000000};
    vecs[1]  = '{1'b1, 3'b001, 1'b0, 1'b0, 9'b110100000};
    vecs[2]  = '{1'b1, 3'b001, 1'b0, 1'b0, 9'b100100000};
    vecs[3]  = '{1'b1, 3'b001, 1'b0, 1'b0, 9'b100100000};
    vecs[4]  = '{1'b1, 3'b001, 1'b0, 1'b1, 9'b100100000};
    vecs[5]  = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b000111010};
    // DIVU by zero
    vecs[6]  = '{1'b1, 3'b100, 1'b1, 1'b0, 9'b000100000};
    vecs[7]  = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b000100010};
    // MTHI then MTLO back to back
    vecs[8]  = '{1'b1, 3'b101, 1'b0, 1'b0, 9'b000100000};
    vecs[9]  = '{1'b1, 3'b110, 1'b0, 1'b0, 9'b000110110};
    vecs[10] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b000101110};
    // none / reserved opcodes, stray unit_done in IDLE
    vecs[11] = '{1'b1, 3'b000, 1'b0, 1'b0, 9'b000100000};
    vecs[12] = '{1'b1, 3'b111, 1'b0, 1'b0, 9'b000100000};
    vecs[13] = '{1'b0, 3'b000, 1'b0, 1'b1, 9'b000100000};
    vecs[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b000100000};
    // DIVU nonzero; done in START ignored; MTHI offered in WRITE ignored
    vecs[15] = '{1'b1, 3'b100, 1'b0, 1'b0, 9'b100100000};
    vecs[16] = '{1'b1, 3'b100, 1'b0, 1'b1, 9'b111000000};
    vecs[17] = '{1'b1, 3'b100, 1'b0, 1'b1, 9'b101000000};
    vecs[18] = '{1'b1, 3'b101, 1'b0, 1'b0, 9'b001011010};
    // DIV accepted right after WRITE, done after 2 WAIT cycles
    vecs[19] = '{1'b1, 3'b011, 1'b0, 1'b0, 9'b101000000};
    vecs[20] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b111100000};
    vecs[21] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b101100000};
    vecs[22] = '{1'b0, 3'b000, 1'b0, 1'b1, 9'b101100000};
    vecs[23] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b001111010};
    vecs[24] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b001100000};

    // Reset values, with a launching op presented during reset.
    rst = 1'b0;
    drive(1'b1, 3'b001, 1'b0, 1'b0);
    #1;
    chk("reset outputs", outs(), 9'b000000000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven cycles: drive at negedge, sample 1 unit later.
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].opv, vecs[i].code, vecs[i].dz, vecs[i].done);
      #1;
      total++;
      if (outs() !== vecs[i].exp) begin
        bad++;
        $display("FAIL vec[%0d]: got %b required %b", i, outs(), vecs[i].exp);
      end
      @(negedge clk);
    end

    // Done arriving exactly on the timeout count: WRITE wins, err stays 0.
    drive(1'b1, 3'b010, 1'b0, 1'b0);
    #1;
    chk("boundary accept stall", stall, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("boundary start outs", outs(), 9'b110000000);
    @(negedge clk);
    stall_ok = 1'b1;
    for (int i = 1; i < 40; i++) begin
      #1;
      if (!stall || op_ack) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk("boundary wait stall", stall_ok, 1'b1);
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    #1;
    chk("boundary last wait stall", stall, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("boundary write outs", outs(), 9'b000011010);
    @(negedge clk);

    // DIV with no done: abort after 40 WAIT cycles.
    drive(1'b1, 3'b011, 1'b0, 1'b0);
    #1;
    chk("timeout accept stall", stall, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("timeout start outs", outs(), 9'b111100000);
    @(negedge clk);
    waits    = 0;
    ack_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (op_ack) begin
        ack_seen = 1'b1;
        break;
      end
      if (stall && !hi_ena && !lo_ena) waits++;
      @(negedge clk);
    end
    chk("timeout ack seen", ack_seen, 1'b1);
    chk("timeout wait cycles", waits, 40);
    chk("timeout ack outs", outs(), 9'b001100011);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("timeout ack one cycle", outs(), 9'b001100001);
    @(negedge clk);
    // A new op is still accepted after the abort.
    drive(1'b1, 3'b101, 1'b0, 1'b0);
    #1;
    chk("post-timeout mthi stall", stall, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("post-timeout mthi outs", outs(), 9'b001110111);
    @(negedge clk);

    // Reset during WAIT, then a late unit_done must be ignored.
    drive(1'b1, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-reset wait stall", stall, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("async reset outs", outs(), 9'b000000000);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    #1;
    chk("post-reset done cycle", outs(), 9'b000000000);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("post-reset no write", outs(), 9'b000000000);
    @(negedge clk);
    #1;
    chk("post-reset still idle", outs(), 9'b000000000);
    @(negedge clk);
    drive(1'b1, 3'b110, 1'b0, 1'b0);
    #1;
    chk("post-reset mtlo stall", stall, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("post-reset mtlo outs", outs(), 9'b000001110);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
